interboard_ctrl_arbiter: RTL

Shares the single interboard transmit port (ctrl_en/move_dir/block_x/block_y/msg_type/card/sel_len) among NUM_REQ game-control requesters (cheat handler, move handler, draw handler, turn handler). Each requester's request is captured into a one-deep slot. Slots are granted round-robin and issued only when the transmitter reports inter_ready. The block sequences each transfer until the transmitter completes, then reports done to the owner. It sits between the GameControl handlers and the interboard sender.

---
 rtl/interboard_ctrl_arbiter_pkg.sv | 49 ++++
 rtl/interboard_ctrl_arbiter_rr_pick.sv | 27 ++
 rtl/interboard_ctrl_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/interboard_ctrl_arbiter_pkg.sv
// Shared definitions for the interboard control arbiter: request message
// packing and the transfer sequencer state encoding.
package interboard_ctrl_arbiter_pkg;

    // Packed request: {move_dir, block_x, block_y, msg_type, card, sel_len}
    localparam int IB_MSG_W      = 22;

    localparam int SEL_LEN_LSB   = 0;
    localparam int SEL_LEN_W     = 3;
    localparam int CARD_LSB      = 3;
    localparam int CARD_W        = 6;
    localparam int MSG_TYPE_LSB  = 9;
    localparam int MSG_TYPE_W    = 4;
    localparam int BLOCK_Y_LSB   = 13;
    localparam int BLOCK_Y_W     = 3;
    localparam int BLOCK_X_LSB   = 16;
    localparam int BLOCK_X_W     = 5;
    localparam int MOVE_DIR_LSB  = 21;

    typedef struct packed {
        logic                  move_dir;
        logic [BLOCK_X_W-1:0]  block_x;
        logic [BLOCK_Y_W-1:0]  block_y;
        logic [MSG_TYPE_W-1:0] msg_type;
        logic [CARD_W-1:0]     card;
        logic [SEL_LEN_W-1:0]  sel_len;
    } ib_msg_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } ib_state_e;

    // Split a raw packed request into its named fields.
    function automatic ib_msg_t unpack_msg(input logic [IB_MSG_W-1:0] raw);
        ib_msg_t m;
        m.move_dir = raw[MOVE_DIR_LSB];
        m.block_x  = raw[BLOCK_X_LSB  +: BLOCK_X_W];
        m.block_y  = raw[BLOCK_Y_LSB  +: BLOCK_Y_W];
        m.msg_type = raw[MSG_TYPE_LSB +: MSG_TYPE_W];
        m.card     = raw[CARD_LSB     +: CARD_W];
        m.sel_len  = raw[SEL_LEN_LSB  +: SEL_LEN_W];
        return m;
    endfunction

endpackage

// File: rtl/interboard_ctrl_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest occupied index at or after
// ptr, wrapping past NUM_REQ-1 back to 0.
module interboard_ctrl_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        idx       = 0;
        any_valid = |valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx])
                grant = IDX_W'(idx);
        end
    end

endmodule

// File: rtl/interboard_ctrl_arbiter.sv
// Shares the single interboard transmit port among NUM_REQ control
// requesters. One-deep slot per requester, round-robin grant, one transfer
// in flight, done pulse back to the owner when the transmitter finishes.
module interboard_ctrl_arbiter
    import interboard_ctrl_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 7,
    parameter int MSG_W     = IB_MSG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     interboard_rst,
    input  logic [NUM_REQ-1:0]       req_en,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    input  logic                     inter_ready,
    output logic [NUM_REQ-1:0]       req_busy,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_drop,
    output logic                     ctrl_en,
    output logic                     ctrl_move_dir,
    output logic [BLOCK_X_W-1:0]     ctrl_block_x,
    output logic [BLOCK_Y_W-1:0]     ctrl_block_y,
    output logic [MSG_TYPE_W-1:0]    ctrl_msg_type,
    output logic [CARD_W-1:0]        ctrl_card,
    output logic [SEL_LEN_W-1:0]     ctrl_sel_len
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_WAIT + 1);

    logic                            sys_rst;
    logic [NUM_REQ-1:0]              slot_vld;
    logic [NUM_REQ-1:0][MSG_W-1:0]   slot_msg;
    logic [NUM_REQ-1:0]              done_vec;

    ib_state_e                       state, state_nxt;
    logic [IDX_W-1:0]                gnt_idx;
    logic [IDX_W-1:0]                ptr;
    logic [IDX_W-1:0]                pick_idx;
    logic                            pick_any;
    logic [CNT_W-1:0]                wait_cnt;
    ib_msg_t                         cur_msg;

    // Peer-board reset behaves exactly like the local one.
    assign sys_rst  = rst | interboard_rst;
    assign req_busy = slot_vld;
    assign req_done = done_vec;

    interboard_ctrl_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid     (slot_vld),
        .ptr       (ptr),
        .grant     (pick_idx),
        .any_valid (pick_any)
    );

    // Slot being released this cycle (DONE state, granted index).
    always_comb begin
        done_vec = '0;
        for (int i = 0; i < NUM_REQ; i++)
            done_vec[i] = (state == ST_DONE) && (gnt_idx == IDX_W'(i));
    end

    // Slot capture/release; a request landing on the freeing cycle is kept.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            slot_vld <= '0;
            slot_msg <= '0;
            req_drop <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_drop[i] <= req_en[i] && slot_vld[i] && !done_vec[i];
                if (done_vec[i])
                    slot_vld[i] <= 1'b0;
                if (req_en[i] && (!slot_vld[i] || done_vec[i])) begin
                    slot_vld[i] <= 1'b1;
                    slot_msg[i] <= req_msg[i*MSG_W +: MSG_W];
                end
            end
        end
    end

    // State register plus grant index, round-robin pointer and ready-wait counter.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            gnt_idx  <= '0;
            ptr      <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE:
                    if (pick_any && inter_ready)
                        gnt_idx <= pick_idx;
                ST_ISSUE:
                    wait_cnt <= '0;
                ST_WAIT_BUSY:
                    wait_cnt <= wait_cnt + 1'b1;
                ST_DONE:
                    ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state logic. The WAIT_BUSY timeout is aligned so that a transmitter
    // which never drops ready reaches DONE exactly BUSY_WAIT cycles after ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (pick_any && inter_ready)
                    state_nxt = ST_ISSUE;
            ST_ISSUE:
                state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY:
                if (!inter_ready)
                    state_nxt = ST_WAIT_DONE;
                else if (wait_cnt == CNT_W'(BUSY_WAIT - 2))
                    state_nxt = ST_DONE;
            ST_WAIT_DONE:
                if (inter_ready)
                    state_nxt = ST_DONE;
            ST_DONE:
                state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: strobe in ISSUE, granted fields held through the transfer, zero otherwise.
    always_comb begin
        cur_msg       = unpack_msg(slot_msg[gnt_idx]);
        ctrl_en       = 1'b0;
        ctrl_move_dir = 1'b0;
        ctrl_block_x  = '0;
        ctrl_block_y  = '0;
        ctrl_msg_type = '0;
        ctrl_card     = '0;
        ctrl_sel_len  = '0;
        if (state == ST_ISSUE || state == ST_WAIT_BUSY || state == ST_WAIT_DONE) begin
            ctrl_en       = (state == ST_ISSUE);
            ctrl_move_dir = cur_msg.move_dir;
            ctrl_block_x  = cur_msg.block_x;
            ctrl_block_y  = cur_msg.block_y;
            ctrl_msg_type = cur_msg.msg_type;
            ctrl_card     = cur_msg.card;
            ctrl_sel_len  = cur_msg.sel_len;
        end
    end

endmodule
